cheese_spawner: RTL

//  Places the cheese on the playfield and re-places it after Jerry takes it.
//  - Consumes the level-type "cheese taken" flag from the collision checker.
//  - Drives the cheese position and visibility seen by the checker and the draw path.
//  - Picks spawn points from a fixed table, or from an LFSR when enabled.
//  - Rejects candidates too close to Jerry, with a bounded retry fallback.

---
 rtl/cheese_spawner.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cheese_spawner.sv
// Cheese placement FSM: picks a spawn point (table or LFSR), keeps it clear of
// Jerry, shows it until taken, then hides it for a cooldown. LFSR mode: CHEESE_SPAWN_LFSR_EN.
module cheese_spawner #(
    parameter int X_MIN          = 16,
    parameter int X_MAX          = 760,
    parameter int X_STEP         = 96,
    parameter int Y_LEVEL0       = 100,
    parameter int Y_LEVEL1       = 250,
    parameter int Y_LEVEL2       = 400,
    parameter int Y_LEVEL3       = 550,
    parameter int EXCL_DIST      = 64,
    parameter int RESPAWN_CYCLES = 100,
    parameter int MAX_TRIES      = 16,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        taken,
    input  logic [10:0] jerry_x,
    input  logic [10:0] jerry_y,
    output logic [10:0] cheese_x,
    output logic [10:0] cheese_y,
    output logic        cheese_visible,
    output logic        spawn_stb
);
    localparam int CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [11:0] EXCL_12  = 12'(EXCL_DIST);
    localparam logic [11:0] X_MAX_12 = 12'(X_MAX);
    localparam logic [11:0] X_MIN_12 = 12'(X_MIN);

    typedef enum logic [1:0] {PLACE, VISIBLE, COOLDOWN} state_t;

    state_t             state_reg, state_next;
    logic [10:0]        x_reg, x_next, y_reg, y_next;
    logic               vis_reg, vis_next, stb_reg, stb_next;
    logic [2:0]         idx_reg, idx_next;
    logic [TRY_W-1:0]   tries_reg, tries_next;
    logic               taken_q_reg, taken_q_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [11:0] cand_x, dx, dy;
    logic [10:0] cand_y;
    logic [1:0]  y_sel;
    logic        reject, accept;

`ifdef CHEESE_SPAWN_LFSR_EN
    logic [15:0] lfsr_reg, lfsr_next;

    // Galois form: shift right, fold taps in when the bit shifted out is 1.
    assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    assign cand_x    = X_MIN_12 + {2'b00, lfsr_reg[9:0]};
    assign y_sel     = lfsr_reg[11:10];

    always_ff @(posedge clk) begin
        if (rst) lfsr_reg <= SEED;
        else     lfsr_reg <= lfsr_next;
    end
`else
    assign cand_x = X_MIN_12 + 12'(int'(idx_reg) * X_STEP);
    assign y_sel  = idx_reg[1:0];
`endif

    always_comb begin
        case (y_sel)
            2'd0:    cand_y = 11'(Y_LEVEL0);
            2'd1:    cand_y = 11'(Y_LEVEL1);
            2'd2:    cand_y = 11'(Y_LEVEL2);
            default: cand_y = 11'(Y_LEVEL3);
        endcase
    end

    assign dx = (cand_x >= {1'b0, jerry_x}) ? cand_x - {1'b0, jerry_x} : {1'b0, jerry_x} - cand_x;
    assign dy = ({1'b0, cand_y} >= {1'b0, jerry_y}) ? {1'b0, cand_y} - {1'b0, jerry_y}
                                                    : {1'b0, jerry_y} - {1'b0, cand_y};
    assign reject = ((dx < EXCL_12) && (dy < EXCL_12)) || (cand_x > X_MAX_12);
    // The last allowed rejection is placed anyway so respawn time stays bounded.
    assign accept = !reject || (tries_reg == TRY_W'(MAX_TRIES - 1));

    always_comb begin
        state_next   = state_reg;
        x_next       = x_reg;
        y_next       = y_reg;
        vis_next     = vis_reg;
        stb_next     = 1'b0;
        idx_next     = idx_reg;
        tries_next   = tries_reg;
        taken_q_next = taken_q_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            PLACE: begin
                idx_next = idx_reg + 3'd1;
                if (accept) begin
                    x_next       = cand_x[10:0];
                    y_next       = cand_y;
                    vis_next     = 1'b1;
                    stb_next     = 1'b1;
                    tries_next   = '0;
                    taken_q_next = 1'b0;
                    state_next   = VISIBLE;
                end else begin
                    tries_next = tries_reg + 1'b1;
                end
            end
            VISIBLE: begin
                taken_q_next = taken;
                if (taken && !taken_q_reg) begin
                    vis_next = 1'b0;
                    if (RESPAWN_CYCLES == 0) begin
                        state_next = PLACE;
                    end else begin
                        state_next = COOLDOWN;
                        cnt_next   = CNT_W'(RESPAWN_CYCLES - 1);
                    end
                end
            end
            COOLDOWN: begin
                if (cnt_reg == '0) state_next = PLACE;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            default: state_next = PLACE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= PLACE;
            x_reg       <= 11'(X_MIN);
            y_reg       <= 11'(Y_LEVEL0);
            vis_reg     <= 1'b0;
            stb_reg     <= 1'b0;
            idx_reg     <= '0;
            tries_reg   <= '0;
            taken_q_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            x_reg       <= x_next;
            y_reg       <= y_next;
            vis_reg     <= vis_next;
            stb_reg     <= stb_next;
            idx_reg     <= idx_next;
            tries_reg   <= tries_next;
            taken_q_reg <= taken_q_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign cheese_x       = x_reg;
    assign cheese_y       = y_reg;
    assign cheese_visible = vis_reg;
    assign spawn_stb      = stb_reg;
endmodule
